// File: rtl/memory_responder_pkg.sv
// ---------------------------------------------------------------------------
// memory_responder_pkg
//  Constants shared between the memory responder and the sequence control.
//  These include the FSM state encodings, the strobe polarities and a few
//  small helpers for sizing and range checking the word array.
// ---------------------------------------------------------------------------
package memory_responder_pkg;

  // Responder FSM states, 3-bit encoding shared with the sequence control
  typedef enum logic [2:0] {
    S_Idle    = 3'd0,
    S_Wait    = 3'd1,
    S_Access  = 3'd2,
    S_Done    = 3'd3,
    S_Release = 3'd4
  } state_e;

  // Both memory strobes are active low
  localparam logic MEM_EN_ACTIVE = 1'b0;
  localparam logic MEM_WR_WRITE  = 1'b0;

  // Address bits needed to index an array of the given depth (at least one)
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // True when a word address falls inside the implemented array
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/memory_array.sv
// ---------------------------------------------------------------------------
// memory_array
//  Single-port synchronous word RAM. Reads are registered: Dout shows the
//  word that was at Addr at the previous rising edge. A write and a read on
//  the same edge return the old contents.
// Ports
//  Clk   in   clock
//  We    in   write enable, active high
//  Addr  in   word address, addr_bits(Depth) wide
//  Din   in   write data
//  Dout  out  registered read data
// ---------------------------------------------------------------------------
module memory_array
   import memory_responder_pkg::*;
#(
   parameter int    DataWidth = 16,
   parameter int    Depth     = 512,
   parameter string InitFile  = "",
   localparam int   AddrBits  = addr_bits(Depth)
) (
   input  logic                 Clk,
   input  logic                 We,
   input  logic [AddrBits-1:0]  Addr,
   input  logic [DataWidth-1:0] Din,
   output logic [DataWidth-1:0] Dout
);

   logic [DataWidth-1:0] mem [Depth];

   // Synchronous write with a registered read of the pre-write contents
   always_ff @(posedge Clk) begin
      if (We) begin
         mem[Addr] <= Din;
      end
      Dout <= mem[Addr];
   end

endmodule

// File: rtl/memory_responder.sv
// ---------------------------------------------------------------------------
// memory_responder
//  Responder end of the sequencer memory strobes. It latches one request per
//  falling strobe, waits WaitStates idle cycles and then performs the access
//  on the word array. It then gives a one-cycle MEM_Rdy pulse, along with the
//  read data and an out-of-range flag.
// Ports
//  Clk       in   clock
//  Reset     in   synchronous active-high reset (array contents survive)
//  MEM_En    in   request strobe, active low
//  MEM_Wr    in   0 = write, 1 = read, sampled with MEM_En
//  Addr      in   word address, sampled with MEM_En
//  DataIn    in   write data, sampled with MEM_En
//  DataOut   out  registered read data, holds the last read value
//  MEM_Rdy   out  one-cycle completion pulse
//  MEM_Busy  out  high whenever the FSM is not idle
//  MEM_Err   out  high with MEM_Rdy when the address was out of range
// ---------------------------------------------------------------------------
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int    DataWidth  = 16,
  parameter int    AddrWidth  = 9,
  parameter int    Depth      = 512,
  parameter int    WaitStates = 0,
  parameter string InitFile   = ""
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 MEM_En,
  input  logic                 MEM_Wr,
  input  logic [AddrWidth-1:0] Addr,
  input  logic [DataWidth-1:0] DataIn,
  output logic [DataWidth-1:0] DataOut,
  output logic                 MEM_Rdy,
  output logic                 MEM_Busy,
  output logic                 MEM_Err
);

  localparam int         ArrAddrBits = addr_bits(Depth);
  localparam logic [3:0] WaitLoad    = 4'(WaitStates);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] data_q;
  logic                 wr_q;
  logic [DataWidth-1:0] dataOut_q;
  logic                 rdy_q;
  logic                 err_q;
  logic                 inRange;
  logic                 ramWe;
  logic [DataWidth-1:0] ramDout;

  assign inRange = addr_in_range(32'(addr_q), Depth);

  // The write fires on the S_Access edge and is gated by Reset. A reset
  // sampled on that same edge therefore aborts the write.
  assign ramWe = (state_q == S_Access) && (wr_q == MEM_WR_WRITE) && inRange && !Reset;

  // The array address comes straight from the request latch. That address is
  // stable from the sampling edge, so the registered read data is valid
  // during S_Done.
  memory_array #(
    .DataWidth (DataWidth),
    .Depth     (Depth),
    .InitFile  (InitFile)
  ) u_array (
    .Clk  (Clk),
    .We   (ramWe),
    .Addr (addr_q[ArrAddrBits-1:0]),
    .Din  (data_q),
    .Dout (ramDout)
  );

  // Next-state logic. The wait counter is loaded with WaitStates and
  // leaves S_Wait once it reaches one, giving exactly WaitStates cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_Idle: begin
        if (MEM_En == MEM_EN_ACTIVE) begin
          cnt_d   = WaitLoad;
          state_d = (WaitLoad != 4'd0) ? S_Wait : S_Access;
        end
      end
      S_Wait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_Access;
        end
      end
      S_Access: state_d = S_Done;
      S_Done: begin
        state_d = (MEM_En == MEM_EN_ACTIVE) ? S_Release : S_Idle;
      end
      S_Release: begin
        if (MEM_En != MEM_EN_ACTIVE) begin
          state_d = S_Idle;
        end
      end
      default: state_d = S_Idle;
    endcase
  end

  // State and output registers. The completion outputs are registered from
  // S_Done, which is where the array read data becomes valid. Reset clears
  // them, so an aborted request can never pulse MEM_Rdy.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_Idle;
      cnt_q     <= '0;
      dataOut_q <= '0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= (state_q == S_Done);
      err_q   <= (state_q == S_Done) && !inRange;
      if ((state_q == S_Done) && (wr_q != MEM_WR_WRITE)) begin
        dataOut_q <= inRange ? ramDout : '0;
      end
    end
  end

  // Request latches. They are only loaded from S_Idle, so changes to the
  // inputs while busy have no effect.
  always_ff @(posedge Clk) begin
    if ((state_q == S_Idle) && (MEM_En == MEM_EN_ACTIVE)) begin
      addr_q <= Addr;
      data_q <= DataIn;
      wr_q   <= MEM_Wr;
    end
  end

  assign DataOut  = dataOut_q;
  assign MEM_Rdy  = rdy_q;
  assign MEM_Err  = err_q;
  assign MEM_Busy = (state_q != S_Idle);

endmodule

// File: tb/tb_memory_responder.sv
// ---------------------------------------------------------------------------
// tb_memory_responder
//  Drives two responders. dutA has no wait states and the full 512-word
//  array. dutB has three wait states and a 256-word array, so it also covers
//  the out-of-range cases. Each request pushes a predicted response from a
//  behavioural memory model into a queue. The scenario task pops that
//  response and compares it with what the DUT returned.
// ---------------------------------------------------------------------------
module tb_memory_responder;

  localparam int WA = 0;
  localparam int WB = 3;
  localparam int DepthA = 512;
  localparam int DepthB = 256;

  typedef struct packed {
    logic [15:0] dout;
    logic        err;
    logic [7:0]  lat;
    logic [7:0]  len;
  } resp_t;

  typedef struct packed {
    logic        w;
    logic [8:0]  a;
    logic [15:0] d;
  } req_t;

  logic        clk = 1'b0;
  logic        rst, enA, enB, wr;
  logic [8:0]  addr;
  logic [15:0] din;
  logic [15:0] doutA, doutB;
  logic        rdyA, rdyB, busyA, busyB, errA, errB;

  resp_t       expQ[$];
  logic [15:0] modelA [DepthA];
  logic [15:0] modelB [DepthA];
  logic [15:0] lastA, lastB;
  int          nCompared = 0;
  int          nMismatched = 0;

  always #5 clk = ~clk;

  memory_responder #(
    .DataWidth(16), .AddrWidth(9), .Depth(DepthA), .WaitStates(WA), .InitFile("")
  ) dutA (
    .Clk(clk), .Reset(rst), .MEM_En(enA), .MEM_Wr(wr), .Addr(addr), .DataIn(din),
    .DataOut(doutA), .MEM_Rdy(rdyA), .MEM_Busy(busyA), .MEM_Err(errA)
  );

  memory_responder #(
    .DataWidth(16), .AddrWidth(9), .Depth(DepthB), .WaitStates(WB), .InitFile("")
  ) dutB (
    .Clk(clk), .Reset(rst), .MEM_En(enB), .MEM_Wr(wr), .Addr(addr), .DataIn(din),
    .DataOut(doutB), .MEM_Rdy(rdyB), .MEM_Busy(busyB), .MEM_Err(errB)
  );

  // Behavioural model: updates the model memory and queues the expected response
  function automatic void predict(input bit selB, input logic w, input logic [8:0] a,
                                  input logic [15:0] d);
    resp_t r;
    int    depth;
    bit    inr;
    depth = selB ? DepthB : DepthA;
    inr   = int'(a) < depth;
    r.lat = selB ? 8'(WB + 2) : 8'(WA + 2);
    r.len = 8'd1;
    r.err = !inr;
    if (selB) begin
      if (w == 1'b0 && inr) modelB[a] = d;
      else if (w == 1'b1) lastB = inr ? modelB[a] : 16'h0000;
      r.dout = lastB;
    end else begin
      if (w == 1'b0 && inr) modelA[a] = d;
      else if (w == 1'b1) lastA = inr ? modelA[a] : 16'h0000;
      r.dout = lastA;
    end
    expQ.push_back(r);
  endfunction

  // One-cycle strobe. Measures edges to MEM_Rdy and the pulse length, and
  // optionally scrambles the request inputs while the DUT is busy.
  task automatic applyStimulus(input bit selB, input logic w, input logic [8:0] a,
                               input logic [15:0] d, input bit toggle, output resp_t obs);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    predict(selB, w, a, d);
    @(negedge clk);
    wr = w; addr = a; din = d;
    if (selB) enB = 1'b0; else enA = 1'b0;
    @(posedge clk); #1;
    enA = 1'b1; enB = 1'b1;
    while (!seen && lat < 40) begin
      if (toggle) begin
        wr = ~wr; addr = 9'($urandom); din = 16'($urandom);
      end
      @(posedge clk); #1;
      lat++;
      seen = selB ? rdyB : rdyA;
    end
    obs.lat  = 8'(lat);
    obs.dout = selB ? doutB : doutA;
    obs.err  = selB ? errB : errA;
    obs.len  = seen ? 8'd1 : 8'd0;
    @(posedge clk); #1;
    if (selB ? rdyB : rdyA) obs.len = obs.len + 8'd1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; enA = 1'b0; enB = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nCompared++;
    if ({doutA, rdyA, busyA, errA} !== 19'h0) begin
      nMismatched++;
      $display("[TB] FAIL reset_A (En held low): got dout=%h rdy=%b busy=%b err=%b, expected all 0",
               doutA, rdyA, busyA, errA);
    end
    nCompared++;
    if ({doutB, rdyB, busyB, errB} !== 19'h0) begin
      nMismatched++;
      $display("[TB] FAIL reset_B: got dout=%h rdy=%b busy=%b err=%b, expected all 0",
               doutB, rdyB, busyB, errB);
    end
    @(negedge clk);
    enA = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lastA = 16'h0; lastB = 16'h0;
    @(posedge clk); #1;
    nCompared++;
    if ({busyA, busyB, rdyA, rdyB} !== 4'b0) begin
      nMismatched++;
      $display("[TB] FAIL post_reset_idle: got busyA=%b busyB=%b rdyA=%b rdyB=%b, expected 0",
               busyA, busyB, rdyA, rdyB);
    end
  endtask

  task automatic test_read_basic();
    req_t  reqs[6];
    resp_t obs, exp;
    reqs = '{'{1'b0, 9'd5, 16'h1234}, '{1'b1, 9'd5, 16'h0},
             '{1'b0, 9'd511, 16'hABCD}, '{1'b1, 9'd511, 16'h0},
             '{1'b0, 9'd0, 16'h0F0F}, '{1'b1, 9'd0, 16'h0}};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, reqs[i].w, reqs[i].a, reqs[i].d, 1'b0, obs);
      exp = expQ.pop_front();
      nCompared++;
      if (obs !== exp) begin
        nMismatched++;
        $display("[TB] FAIL read_basic[%0d]: got dout=%h err=%b lat=%0d len=%0d, expected dout=%h err=%b lat=%0d len=%0d",
                 i, obs.dout, obs.err, obs.lat, obs.len, exp.dout, exp.err, exp.lat, exp.len);
      end
    end
  endtask

  task automatic test_hold();
    resp_t obs, exp;
    int    busyLow;
    obs = '0;
    busyLow = 0;
    predict(1'b0, 1'b1, 9'd5, 16'h0);
    @(negedge clk);
    wr = 1'b1; addr = 9'd5; enA = 1'b0;
    @(posedge clk); #1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (rdyA) begin
        if (obs.len == 8'd0) begin
          obs.lat = 8'(i); obs.dout = doutA; obs.err = errA;
        end
        obs.len = obs.len + 8'd1;
      end
      if (!busyA) busyLow++;
    end
    exp = expQ.pop_front();
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL hold_pulse: got dout=%h err=%b lat=%0d pulses=%0d, expected dout=%h err=%b lat=%0d pulses=%0d",
               obs.dout, obs.err, obs.lat, obs.len, exp.dout, exp.err, exp.lat, exp.len);
    end
    @(negedge clk);
    enA = 1'b1;
    @(posedge clk); #1;
    nCompared++;
    if (busyLow != 0 || busyA !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL hold_busy: got busy-low cycles=%0d busy-after-release=%b, expected 0 and 0",
               busyLow, busyA);
    end
  endtask

  task automatic test_write_read_wait();
    resp_t obs, exp;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, (i == 1), 9'd9, 16'hBEEF, 1'b0, obs);
      exp = expQ.pop_front();
      nCompared++;
      if (obs !== exp) begin
        nMismatched++;
        $display("[TB] FAIL write_read_wait[%0d]: got dout=%h err=%b lat=%0d len=%0d, expected dout=%h err=%b lat=%0d len=%0d",
                 i, obs.dout, obs.err, obs.lat, obs.len, exp.dout, exp.err, exp.lat, exp.len);
      end
    end
  endtask

  task automatic test_range();
    req_t  reqs[8];
    resp_t obs, exp;
    reqs = '{'{1'b0, 9'd44, 16'hABCD}, '{1'b1, 9'd44, 16'h0},
             '{1'b0, 9'd300, 16'h5555}, '{1'b1, 9'd300, 16'h0},
             '{1'b1, 9'd44, 16'h0}, '{1'b0, 9'd255, 16'h7E7E},
             '{1'b1, 9'd255, 16'h0}, '{1'b1, 9'd256, 16'h0}};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, reqs[i].w, reqs[i].a, reqs[i].d, 1'b0, obs);
      exp = expQ.pop_front();
      nCompared++;
      if (obs !== exp) begin
        nMismatched++;
        $display("[TB] FAIL range[%0d]: got dout=%h err=%b lat=%0d len=%0d, expected dout=%h err=%b lat=%0d len=%0d",
                 i, obs.dout, obs.err, obs.lat, obs.len, exp.dout, exp.err, exp.lat, exp.len);
      end
    end
  endtask

  task automatic test_toggle();
    resp_t obs, exp;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, (i == 1), 9'd20, 16'h1111, 1'b1, obs);
      exp = expQ.pop_front();
      nCompared++;
      if (obs !== exp) begin
        nMismatched++;
        $display("[TB] FAIL toggle[%0d]: got dout=%h err=%b lat=%0d len=%0d, expected dout=%h err=%b lat=%0d len=%0d",
                 i, obs.dout, obs.err, obs.lat, obs.len, exp.dout, exp.err, exp.lat, exp.len);
      end
    end
  endtask

  task automatic test_reset_abort();
    resp_t obs, exp;
    int    rdySeen;
    rdySeen = 0;
    applyStimulus(1'b1, 1'b0, 9'd7, 16'h0000, 1'b0, obs);
    exp = expQ.pop_front();
    @(negedge clk);
    wr = 1'b0; addr = 9'd7; din = 16'h7777; enB = 1'b0;
    @(posedge clk); #1;
    enB = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    lastA = 16'h0; lastB = 16'h0;
    nCompared++;
    if ({doutB, rdyB, busyB, errB} !== 19'h0) begin
      nMismatched++;
      $display("[TB] FAIL abort_outputs: got dout=%h rdy=%b busy=%b err=%b, expected all 0",
               doutB, rdyB, busyB, errB);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rdyB) rdySeen++;
    end
    nCompared++;
    if (rdySeen != 0) begin
      nMismatched++;
      $display("[TB] FAIL abort_no_rdy: got %0d MEM_Rdy cycles, expected 0", rdySeen);
    end
    applyStimulus(1'b1, 1'b1, 9'd7, 16'h0, 1'b0, obs);
    exp = expQ.pop_front();
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL abort_readback: got dout=%h err=%b lat=%0d len=%0d, expected dout=%h err=%b lat=%0d len=%0d",
               obs.dout, obs.err, obs.lat, obs.len, exp.dout, exp.err, exp.lat, exp.len);
    end
  endtask

  initial begin
    rst = 1'b1; enA = 1'b1; enB = 1'b1; wr = 1'b1; addr = '0; din = '0;
    lastA = 16'h0; lastB = 16'h0;
    test_reset();
    test_read_basic();
    test_hold();
    test_write_read_wait();
    test_range();
    test_toggle();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
